// File: rtl/legendre_pkg.sv
// Shared widths, saturation limits and FSM state type for the Legendre
// product-accumulate stage.
package legendre_pkg;

   localparam int A_W       = 18;
   localparam int B_W       = 18;
   localparam int P_W       = 35;
   localparam int ACC_W     = 40;
   localparam int MAX_TERMS = 32;
   localparam int CNT_W     = 6;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      HOLD
   } state_t;

endpackage

// File: rtl/legendre_mul18.sv
// Two-stage signed multiplier: registered operands (loaded on en) feeding a
// registered product.
module legendre_mul18 #(
   parameter int A_W  = 18,
   parameter int B_W  = 18,
   parameter int PR_W = 36
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic signed [A_W-1:0]  a,
   input  logic signed [B_W-1:0]  b,
   output logic signed [PR_W-1:0] p
);

   logic signed [A_W-1:0] a_q;
   logic signed [B_W-1:0] b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         p   <= '0;
      end else begin
         if (en) begin
            a_q <= a;
            b_q <= b;
         end
         p <= PR_W'(a_q) * PR_W'(b_q);
      end
   end

endmodule

// File: rtl/legendre_product_accum.sv
// Saturating signed multiply-accumulate per segment with a single-entry,
// valid/ready output buffer.
module legendre_product_accum #(
   parameter int A_W       = legendre_pkg::A_W,
   parameter int B_W       = legendre_pkg::B_W,
   parameter int P_W       = legendre_pkg::P_W,
   parameter int ACC_W     = legendre_pkg::ACC_W,
   parameter int MAX_TERMS = legendre_pkg::MAX_TERMS,
   parameter int CNT_W     = legendre_pkg::CNT_W
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic signed [A_W-1:0]   in_a,
   input  logic signed [B_W-1:0]   in_b,
   input  logic                    in_last,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0]        out_cnt,
   output logic                    out_sat,
   output logic                    out_ovf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   import legendre_pkg::*;

   // One guard bit: (-2^(A_W-1)) * (-2^(B_W-1)) does not fit in P_W signed bits.
   localparam int PR_W = P_W + 1;
   localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t state, state_next;

   logic                    accept, close, hit_max;
   logic [CNT_W-1:0]        cnt, cnt_inc;
   logic                    v0, v1, c0, c1, c2;
   logic signed [PR_W-1:0]  prod;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic signed [ACC_W:0]   sum_ext;
   logic                    sat, sat_next, ovf;

   legendre_mul18 #(
      .A_W  (A_W),
      .B_W  (B_W),
      .PR_W (PR_W)
   ) u_mul (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .en    (accept),
      .a     (in_a),
      .b     (in_b),
      .p     (prod)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      accept     = in_valid && in_ready;
      cnt_inc    = cnt + 1'b1;
      hit_max    = (cnt_inc == CNT_W'(MAX_TERMS));
      close      = accept && (in_last || hit_max);
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = close ? DRAIN : ACCUM;
         ACCUM:   if (close)  state_next = DRAIN;
         DRAIN:   if (c2)     state_next = HOLD;
         HOLD:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sum_ext  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
      acc_next = sum_ext[ACC_W-1:0];
      sat_next = sat;
      if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
         acc_next = sum_ext[ACC_W] ? SUM_MIN : SUM_MAX;
         sat_next = 1'b1;
      end
   end

   // c0..c2 track the closing term through operand, product and accumulator.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         v0        <= 1'b0;
         v1        <= 1'b0;
         c0        <= 1'b0;
         c1        <= 1'b0;
         c2        <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         sat       <= 1'b0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_cnt   <= '0;
         out_sat   <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         in_ready  <= (state_next == IDLE) || (state_next == ACCUM);
         out_valid <= (state_next == HOLD);
         v0        <= accept;
         v1        <= v0;
         c0        <= close;
         c1        <= c0;
         c2        <= c1;

         if (accept)                             cnt <= cnt_inc;
         else if (state == IDLE || state == HOLD) cnt <= '0;

         if (v1) begin
            acc <= acc_next;
            sat <= sat_next;
         end else if (state == IDLE || state == HOLD) begin
            acc <= '0;
            sat <= 1'b0;
         end

         if (close) ovf <= hit_max && !in_last;

         if (state == DRAIN && c2) begin
            out_sum <= acc;
            out_cnt <= cnt;
            out_sat <= sat;
            out_ovf <= ovf;
         end
      end
   end

endmodule
